// File: rtl/types_pkg.sv
// Shared types for the stream-cipher byte-input receiver and the chip output path.
package types_pkg;

  localparam int unsigned BYTE_W = 8;

  // Handshake state; any non-I_IDLE value becomes the input_acknowledged pin.
  typedef enum logic {
    I_IDLE = 1'b0,
    I_ACK  = 1'b1
  } interface_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO between the input handshake and the cipher core.
// Registered full/empty flags, no fall-through, synchronous flush.
module byte_fifo
  import types_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;

  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_nxt;

  // Push is judged on the registered full flag, so full+pop blocks the push this cycle.
  assign w_push = push & ~r_full;
  assign w_pop  = pop & ~r_empty;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage, pointers and flags; flush empties the queue without touching storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == CNT_W'(0));
    end
  end

  assign head  = r_empty ? '0 : r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/input_receiver.sv
// Chip-side receiver for the user byte-input 4-phase handshake.
// Optional build macro INPUT_SYNC_EN: 2-flop synchroniser on input_valid.
module input_receiver
  import types_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              input_valid,
  input  logic              flush,
  output interface_state_t  interface_state,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              fifo_full,
  output logic [CNT_W-1:0]  bytes_received
);

  interface_state_t r_state;
  interface_state_t w_state_nxt;
  logic             w_v_s;
  logic             w_push;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] r_bytes_received;

`ifdef INPUT_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchroniser on the asynchronous user strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= input_valid;
      r_sync2 <= r_sync1;
    end
  end

  assign w_v_s = r_sync2;
`else
  assign w_v_s = input_valid;
`endif

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= I_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and push strobe: one capture per strobe, withheld while the FIFO is full.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      I_IDLE: begin
        if (w_v_s && !fifo_full) begin
          w_push      = 1'b1;
          w_state_nxt = I_ACK;
        end
      end
      I_ACK: begin
        if (!w_v_s) w_state_nxt = I_IDLE;
      end
      default: w_state_nxt = I_IDLE;
    endcase
  end

  // Accepted-byte counter; counts even when a same-cycle flush drops the byte.
  always_ff @(posedge clk) begin
    if (rst)         r_bytes_received <= '0;
    else if (w_push) r_bytes_received <= r_bytes_received + CNT_W'(1);
  end

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_byte_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (byte_ready),
    .flush (flush),
    .din   (data_in),
    .head  (byte_out),
    .full  (fifo_full),
    .empty (w_fifo_empty)
  );

  assign interface_state = r_state;
  assign byte_valid      = ~w_fifo_empty;
  assign bytes_received  = r_bytes_received;

endmodule

// File: tb/tb_input_receiver.sv
// Scoreboard bench for input_receiver: stimulus queues expected bytes, a negedge
// monitor checks every byte the core consumes; directed checks cover state and flags.
module tb_input_receiver;
  import types_pkg::*;

`ifdef INPUT_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       data_in = '0;
  logic             input_valid = 1'b0;
  logic             flush = 1'b0;
  interface_state_t interface_state;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready = 1'b0;
  logic             fifo_full;
  logic [15:0]      bytes_received;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [7:0]       exp_q[$];
  int               k;

  always #5 clk = ~clk;

  input_receiver #(
    .DEPTH(4),
    .CNT_W(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .input_valid     (input_valid),
    .flush           (flush),
    .interface_state (interface_state),
    .byte_out        (byte_out),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .fifo_full       (fifo_full),
    .bytes_received  (bytes_received)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a handshake state; returns cycles spent.
  task automatic wait_state(input interface_state_t s, input string name, output int cyc);
    cyc = 0;
    while (interface_state !== s && cyc < 20) begin
      tick();
      cyc++;
    end
    chk(name, 32'(interface_state), 32'(s));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(interface_state), 32'(I_IDLE));
    chk({tag, "_bvalid"}, 32'(byte_valid), 32'(0));
    chk({tag, "_full"}, 32'(fifo_full), 32'(0));
    chk({tag, "_bout"}, 32'(byte_out), 32'(0));
    chk({tag, "_count"}, 32'(bytes_received), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    input_valid = 1'b0;
    flush = 1'b0;
    byte_ready = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Full 4-phase handshake for one byte.
  task automatic send(input logic [7:0] b);
    int c;
    exp_q.push_back(b);
    data_in = b;
    input_valid = 1'b1;
    wait_state(I_ACK, "send_ack", c);
    input_valid = 1'b0;
    wait_state(I_IDLE, "send_release", c);
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    byte_ready = 1'b1;
    while (byte_valid && c < 20) begin
      tick();
      c++;
    end
    byte_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(byte_valid), 32'(0));
    chk({tag, "_drain_left"}, 32'(exp_q.size()), 32'(0));
  endtask

  // Monitor: a byte is consumed at the next edge whenever valid & ready.
  always @(negedge clk) begin
    if (!rst && byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got %0h, expected no byte", byte_out);
      end else begin
        chk("pop_data", 32'(byte_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    tick();

    // 1: single byte, valid high 3 cycles
    exp_q.push_back(8'hA5);
    data_in = 8'hA5;
    input_valid = 1'b1;
    wait_state(I_ACK, "t1_ack", k);
    chk("t1_ack_lat", 32'(k), 32'(1 + SL));
    chk("t1_bvalid", 32'(byte_valid), 32'(1));
    chk("t1_bout", 32'(byte_out), 32'hA5);
    chk("t1_count", 32'(bytes_received), 32'(1));
    if (k < 3) repeat (3 - k) tick();
    input_valid = 1'b0;
    wait_state(I_IDLE, "t1_idle", k);
    chk("t1_rel_lat", 32'(k), 32'(1 + SL));
    chk("t1_count_hold", 32'(bytes_received), 32'(1));
    drain("t1");

    // 2: fill, blocked 5th byte, pop releases it
    do_reset();
    for (int i = 1; i <= 4; i++) send(8'(i));
    chk("t2_full", 32'(fifo_full), 32'(1));
    chk("t2_count4", 32'(bytes_received), 32'(4));
    exp_q.push_back(8'h05);
    data_in = 8'h05;
    input_valid = 1'b1;
    repeat (3 + SL) tick();
    chk("t2_no_ack", 32'(interface_state), 32'(I_IDLE));
    chk("t2_no_count", 32'(bytes_received), 32'(4));
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    chk("t2_blocked", 32'(interface_state), 32'(I_IDLE));
    chk("t2_notfull", 32'(fifo_full), 32'(0));
    tick();
    chk("t2_retry_ack", 32'(interface_state), 32'(I_ACK));
    chk("t2_count5", 32'(bytes_received), 32'(5));
    chk("t2_refull", 32'(fifo_full), 32'(1));
    input_valid = 1'b0;
    wait_state(I_IDLE, "t2_idle", k);
    drain("t2");

    // 3: continuous drain order
    do_reset();
    byte_ready = 1'b1;
    send(8'h10);
    send(8'h20);
    send(8'h30);
    repeat (4) tick();
    chk("t3_empty", 32'(byte_valid), 32'(0));
    chk("t3_left", 32'(exp_q.size()), 32'(0));
    chk("t3_count", 32'(bytes_received), 32'(3));
    byte_ready = 1'b0;

    // 4: flush
    do_reset();
    send(8'h11);
    send(8'h22);
    chk("t4_pre_valid", 32'(byte_valid), 32'(1));
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    chk("t4_flushed", 32'(byte_valid), 32'(0));
    chk("t4_count", 32'(bytes_received), 32'(2));
    chk("t4_full", 32'(fifo_full), 32'(0));
    send(8'h33);
    chk("t4_head", 32'(byte_out), 32'h33);
    chk("t4_count3", 32'(bytes_received), 32'(3));
    drain("t4");

    // 5: reset during I_ACK with valid still high
    do_reset();
    data_in = 8'h5A;
    input_valid = 1'b1;
    wait_state(I_ACK, "t5_ack", k);
    rst = 1'b1;
    tick();
    chk_reset_vals("t5_rst");
    exp_q.delete();
    exp_q.push_back(8'h5A);
    rst = 1'b0;
    wait_state(I_ACK, "t5_reack", k);
    chk("t5_count", 32'(bytes_received), 32'(1));
    chk("t5_bout", 32'(byte_out), 32'h5A);
    input_valid = 1'b0;
    wait_state(I_IDLE, "t5_idle", k);
    drain("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
